aes128_key_sched_ctrl: RTL and testbench
========================================

Name: aes128_key_sched_ctrl

Overview:
- Sequential AES-128 key-schedule controller. Accepts a cipher key through a valid/ready handshake and iterates one key-expansion round per clock.
- Stores round keys 0..10 in an internal register file and serves them by index to the round engine.
- Replaces the all-combinational 10-stage expansion with a single shared round datapath, trading 10 cycles of latency for area.

Parameters:
- WIDTH, 128, key/round-key width in bits (only 128 supported)
- NR, 10, number of expanded rounds; round keys indexed 0..NR

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- key_valid_i  input  1  cipher key offered
- key_i  input  WIDTH  cipher key, byte 0 at [127:120]
- key_ready_o  output  1  controller can accept a key
- busy_o  output  1  expansion in progress
- done_o  output  1  one-cycle pulse when round key NR has been written
- rk_rd_i  input  1  round-key read request
- rk_idx_i  input  4  round-key index, 0..NR
- rk_o  output  WIDTH  registered round key
- rk_valid_o  output  1  rk_o holds a valid key for the previous cycle's request
- rk_err_o  output  1  previous request was out of range or for a key not yet generated

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - FSM to IDLE; round counter cnt=0; gen_cnt=0.
  - All outputs 0 except key_ready_o=1.
  - Register file contents are don't-care; gen_cnt=0 makes them invalid.
- FSM states: IDLE, EXPAND, READY.
- IDLE / READY:
  - key_ready_o=1.
  - Handshake when key_valid_i && key_ready_o: rk[0] <= key_i, cnt <= 1, gen_cnt <= 1, go to EXPAND.
  - A new key in READY flushes the previous schedule (gen_cnt restarts at 1).
- EXPAND:
  - key_ready_o=0, busy_o=1.
  - Each cycle: rk[cnt] <= key_round(rk[cnt-1], rcon[cnt]); cnt++, gen_cnt++.
  - When cnt==NR is written: go to READY and pulse done_o in that same edge's following cycle.
  - Key accepted at edge 0; rk[1] written at edge 1; rk[10] written at edge 10; done_o high during cycle 10→11.
  - key_valid_i is ignored while in EXPAND.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; it is a constant table, not a shift register.
- Round function (word-wise, w0..w3 = prev[127:96]..prev[31:0]):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- Read port (1-cycle latency, usable in any state):
  - If rk_rd_i and rk_idx_i < gen_cnt: next cycle rk_o = rk[idx], rk_valid_o=1, rk_err_o=0.
  - If rk_rd_i and (rk_idx_i > NR or rk_idx_i >= gen_cnt): rk_o=0, rk_valid_o=0, rk_err_o=1.
  - If no request: rk_valid_o=0, rk_err_o=0, rk_o holds its last value.
- Simultaneous events:
  - Read of index k in the same cycle rk[k] is written reports error, since gen_cnt has not yet updated.
  - Read during a flush uses the pre-flush gen_cnt sampled that cycle. The returned data may be new rk[0] if idx=0; the bench accepts either old or new rk[0].
- Reset mid-EXPAND aborts immediately: IDLE, gen_cnt=0, done_o is never pulsed.

Decomposition:
- Shared package aes_pkg: WIDTH, NR, rcon table, S-box function sbox(byte), and the FSM state enum.
- Sub-module aes_key_round (combinational): prev_key_i[127:0], rcon_i[7:0] -> next_key_o[127:0]; instantiates 4 S-box lookups.
- The controller holds the FSM, counters, the 11x128 register file and the read port.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done_o pulses exactly 10 cycles after the handshake.
  - Read idx 1 -> a0fafe1788542cb123a339392a6c7605, rk_valid_o=1.
  - Read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read during EXPAND:
  - idx 0 the cycle after handshake -> key_i returned.
  - idx 5 at the same cycle -> rk_err_o=1, rk_valid_o=0.
- Read idx 11 and idx 15 in READY -> rk_err_o=1, rk_o=0. Back-to-back reads idx 0..10 -> all valid, one per cycle.
- key_valid_i held high during EXPAND with a different key -> ignored, key_ready_o=0. The original schedule completes unchanged.
- Flush in READY with all-zero key -> idx 10 reads b4ef5bcb3e92e21123e951cf6f8f188e after the new done_o.
- Assert rst_n_i low at EXPAND cycle 4 (asynchronously, mid-cycle) -> outputs clear immediately, no done_o. Read idx 0 after reset -> rk_err_o=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, round constants,
// S-box lookup and the controller state encoding.
package aes_pkg;

    localparam int WIDTH = 128;
    localparam int NR    = 10;

    // Round constant per expansion round; entry 0 and 11..15 are unused padding
    // so that a 4-bit round counter can index the table directly.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: derives round key n from round key n-1.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [WIDTH-1:0] prev_key_i,
    input  logic [7:0]       rcon_i,
    output logic [WIDTH-1:0] next_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word, sub_word, t_word;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key_i[127:96];
    assign w1 = prev_key_i[95:64];
    assign w2 = prev_key_i[63:32];
    assign w3 = prev_key_i[31:0];

    // RotWord: cyclic left rotate by one byte
    assign rot_word = {w3[23:0], w3[31:24]};

    // SubWord: four independent S-box lookups
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_word = sub_word ^ {rcon_i, 24'h000000};

    assign n0 = w0 ^ t_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Sequential AES-128 key-schedule controller: one shared round datapath,
// one round key per clock, round keys 0..NR kept in a register file and
// served through a registered read port.
module aes128_key_sched_ctrl #(
    parameter int WIDTH = aes_pkg::WIDTH,   // only 128 is supported
    parameter int NR    = aes_pkg::NR
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             key_valid_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             key_ready_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic             rk_rd_i,
    input  logic [3:0]       rk_idx_i,
    output logic [WIDTH-1:0] rk_o,
    output logic             rk_valid_o,
    output logic             rk_err_o
);

    import aes_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [3:0]       gen_cnt_reg;
    logic [WIDTH-1:0] cur_key_reg;
    logic             key_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] rk_reg;
    logic             rk_valid_reg;
    logic             rk_err_reg;

    logic [WIDTH-1:0] rk_mem [0:NR];

    logic             accept;
    logic [7:0]       rcon_cur;
    logic [WIDTH-1:0] next_key;

    // key_ready_reg is low exactly while expanding, so keys offered then are ignored
    assign accept   = key_valid_i && key_ready_reg;
    assign rcon_cur = RCON[cnt_reg];

    // The previous round key lives in cur_key_reg so the datapath never reads the array
    aes_key_round u_round (
        .prev_key_i (cur_key_reg),
        .rcon_i     (rcon_cur),
        .next_key_o (next_key)
    );

    // Register file write: cipher key at slot 0 on handshake, then one round key per cycle
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rk_mem[0] <= key_i;
        end else if (state_reg == ST_EXPAND) begin
            rk_mem[cnt_reg] <= next_key;
        end
    end

    // Controller FSM with counters and registered status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            gen_cnt_reg   <= 4'd0;
            cur_key_reg   <= '0;
            key_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        cur_key_reg   <= key_i;
                        cnt_reg       <= 4'd1;
                        gen_cnt_reg   <= 4'd1;
                        key_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    cur_key_reg <= next_key;
                    gen_cnt_reg <= gen_cnt_reg + 4'd1;
                    if (cnt_reg == LAST_IDX) begin
                        cnt_reg       <= 4'd0;
                        key_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_READY;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Read port: only keys already written (idx < gen_cnt) are valid; data held when idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rk_reg       <= '0;
            rk_valid_reg <= 1'b0;
            rk_err_reg   <= 1'b0;
        end else if (rk_rd_i) begin
            if ((rk_idx_i < gen_cnt_reg) && (rk_idx_i <= LAST_IDX)) begin
                rk_reg       <= rk_mem[rk_idx_i];
                rk_valid_reg <= 1'b1;
                rk_err_reg   <= 1'b0;
            end else begin
                rk_reg       <= '0;
                rk_valid_reg <= 1'b0;
                rk_err_reg   <= 1'b1;
            end
        end else begin
            rk_valid_reg <= 1'b0;
            rk_err_reg   <= 1'b0;
        end
    end

    assign key_ready_o = key_ready_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign rk_o        = rk_reg;
    assign rk_valid_o  = rk_valid_reg;
    assign rk_err_o    = rk_err_reg;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed testbench for aes128_key_sched_ctrl using FIPS-197 vectors.
module tb_aes128_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         rk_rd;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         rk_valid;
    logic         rk_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic seen_done;

    logic [127:0] fips_rk [0:10];
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_key_sched_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .key_valid_i (key_valid),
        .key_i       (key),
        .key_ready_o (key_ready),
        .busy_o      (busy),
        .done_o      (done),
        .rk_rd_i     (rk_rd),
        .rk_idx_i    (rk_idx),
        .rk_o        (rk),
        .rk_valid_o  (rk_valid),
        .rk_err_o    (rk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a read at this negedge, sample the result one cycle later
    task automatic do_read(input logic [3:0] idx, input logic ev, input logic ee,
                           input logic [127:0] ed);
        rk_rd  = 1'b1;
        rk_idx = idx;
        @(negedge clk);
        $display("read idx %0d: valid=%0b err=%0b data=%h", idx, rk_valid, rk_err, rk);
        check("rd_valid", {127'd0, rk_valid}, {127'd0, ev});
        check("rd_err",   {127'd0, rk_err},   {127'd0, ee});
        check("rd_data",  rk, ed);
    endtask

    // Count edges after the handshake edge until done_o is seen (bounded)
    task automatic wait_done(inout int c);
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n = 1'b0; key_valid = 1'b0; key = '0; rk_rd = 1'b0; rk_idx = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_key_ready", {127'd0, key_ready}, 128'd1);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_done",      {127'd0, done},      128'd0);
        check("rst_rk_valid",  {127'd0, rk_valid},  128'd0);
        check("rst_rk_err",    {127'd0, rk_err},    128'd0);
        check("rst_rk",        rk,                  128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nothing generated yet
        do_read(4'd0, 1'b0, 1'b1, 128'd0);
        rk_rd = 1'b0;

        // FIPS-197 key load
        key_valid = 1'b1; key = FIPS_KEY;
        @(negedge clk);
        $display("key loaded %h", FIPS_KEY);
        key_valid = 1'b0;
        cyc = 0;
        check("exp_busy",      {127'd0, busy},      128'd1);
        check("exp_key_ready", {127'd0, key_ready}, 128'd0);
        do_read(4'd0, 1'b1, 1'b0, FIPS_KEY);   // rk[0] available the cycle after handshake
        do_read(4'd5, 1'b0, 1'b1, 128'd0);     // rk[5] not yet generated
        rk_rd = 1'b0;
        cyc = 2;
        wait_done(cyc);
        check("done_latency", 128'(cyc), 128'd10);
        @(negedge clk);
        check("done_pulse_end", {127'd0, done},      128'd0);
        check("ready_after",    {127'd0, key_ready}, 128'd1);
        check("busy_after",     {127'd0, busy},      128'd0);

        // Back-to-back reads of the whole schedule
        for (int i = 0; i <= 10; i++) begin
            do_read(4'(i), 1'b1, 1'b0, fips_rk[i]);
        end
        do_read(4'd11, 1'b0, 1'b1, 128'd0);
        do_read(4'd15, 1'b0, 1'b1, 128'd0);
        do_read(4'd3,  1'b1, 1'b0, fips_rk[3]);
        rk_rd = 1'b0;
        @(negedge clk);
        check("idle_valid", {127'd0, rk_valid}, 128'd0);
        check("idle_err",   {127'd0, rk_err},   128'd0);
        check("idle_hold",  rk, fips_rk[3]);

        // Key offered continuously during expansion with a different value
        key_valid = 1'b1; key = FIPS_KEY;
        @(negedge clk);
        $display("key loaded %h, then zero key held valid", FIPS_KEY);
        key = '0;
        cyc = 0;
        while (!done && cyc < 40) begin
            check("hold_ready_low", {127'd0, key_ready}, 128'd0);
            @(negedge clk);
            cyc++;
        end
        key_valid = 1'b0;
        check("hold_done_latency", 128'(cyc), 128'd10);
        do_read(4'd10, 1'b1, 1'b0, fips_rk[10]);
        do_read(4'd0,  1'b1, 1'b0, FIPS_KEY);
        rk_rd = 1'b0;

        // Flush from READY with the all-zero key
        key_valid = 1'b1; key = '0;
        @(negedge clk);
        $display("key loaded %h", 128'd0);
        key_valid = 1'b0;
        cyc = 0;
        wait_done(cyc);
        check("flush_done_latency", 128'(cyc), 128'd10);
        do_read(4'd10, 1'b1, 1'b0, ZERO_RK10);
        do_read(4'd0,  1'b1, 1'b0, 128'd0);
        do_read(4'd1,  1'b1, 1'b0, ZERO_RK1);
        rk_rd = 1'b0;

        // Asynchronous reset in the middle of an expansion
        key_valid = 1'b1; key = FIPS_KEY;
        @(negedge clk);
        $display("key loaded %h, reset mid-expansion", FIPS_KEY);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      {127'd0, busy},      128'd0);
        check("mid_rst_key_ready", {127'd0, key_ready}, 128'd1);
        check("mid_rst_done",      {127'd0, done},      128'd0);
        check("mid_rst_rk",        rk,                  128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("mid_rst_no_done", {127'd0, seen_done}, 128'd0);
        do_read(4'd0, 1'b0, 1'b1, 128'd0);
        rk_rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
